cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the SS common-data-bus (CDB) lanes among FU_COUNT functional units.
- Each cycle it grants up to SS requesting FUs in round-robin order and registers their results onto the CDB lanes.
- The ROB (commit flag), reservation stations and physical regfile consume the CDB lanes one cycle after grant.
- FUs that are not granted stall via valid/ready backpressure.

Parameters:
- SS, 2, number of CDB lanes (superscalar width).
- FU_COUNT, 4, number of requesting functional units; must be >= SS.
- ROB_DEPTH, 8, ROB entries; ROB_IDX_W = $clog2(ROB_DEPTH) (localparam).
- PREG_W, 6, physical register index width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  pipeline flush, synchronous, active-high.
- fu_valid  input  [FU_COUNT]  FU i holds a completed result.
- fu_rob_id  input  [FU_COUNT][ROB_IDX_W]  ROB id of FU i's result.
- fu_pd  input  [FU_COUNT][PREG_W]  destination physical register.
- fu_rd_v  input  [FU_COUNT][32]  result value.
- fu_ready  output  [FU_COUNT]  FU i granted this cycle; transfer occurs when fu_valid[i] && fu_ready[i].
- cdb_valid  output  [SS]  lane k broadcasting.
- cdb_rob_id  output  [SS][ROB_IDX_W]  lane k ROB id.
- cdb_pd  output  [SS][PREG_W]  lane k physical destination.
- cdb_rd_v  output  [SS][32]  lane k value.
- cdb_fu_idx  output  [SS][$clog2(FU_COUNT)]  source FU of lane k.
- bcast_count  output  32  total broadcasts since reset.

Behaviour:
- State:
  - Round-robin pointer ptr [$clog2(FU_COUNT)].
  - Registered lane outputs.
  - bcast_count.
- Reset (async, rst=1):
  - ptr=0, cdb_valid=0, cdb_rob_id/pd/rd_v/fu_idx=0, bcast_count=0.
  - fu_ready=0 while rst is asserted.
- Grant (combinational, same cycle as fu_valid):
  - Scan FU indices ptr, ptr+1, ..., ptr+FU_COUNT-1, all mod FU_COUNT.
  - The first min(SS, #valid) valid FUs get fu_ready=1. The k-th granted FU in scan order maps to lane k.
  - fu_ready=0 for every FU that is not valid.
- Latency: a granted result appears on its lane exactly 1 cycle after the grant edge. There is no internal queue beyond the lane registers.
- Ungranted lanes: cdb_valid[k]=0 next cycle; payload is don't-care but held at its previous value.
- Pointer update:
  - If at least one grant: ptr <= (index of last granted FU + 1) mod FU_COUNT.
  - If no grant: ptr unchanged.
- FU contract:
  - While fu_valid && !fu_ready, the FU holds valid and payload stable.
  - The arbiter never drops or duplicates a result. Each transfer yields exactly one broadcast.
- Counter:
  - bcast_count += popcount(grants) each non-flush cycle, wrapping mod 2^32.
  - Its visible value lags grants by one cycle, matching cdb_valid.
- flush=1:
  - fu_ready forced to 0 (no transfers).
  - cdb_valid <= 0 at the next edge.
  - ptr and bcast_count unchanged.
  - Results already on the CDB in the flush cycle are still visible that cycle.
- Simultaneous cases:
  - Flush together with valid requests: flush wins.
  - FU_COUNT valid with SS lanes: exactly SS grants.
  - All FUs idle: no grants, ptr holds.
- Wrap-around: the scan crosses index FU_COUNT-1 to 0 with no gap or bias.
- Fairness: a continuously valid FU is granted within ceil(FU_COUNT/SS) cycles.

Test Plan:
- Reset, then all 4 FUs valid with rob_ids 4,5,6,7:
  - Cycle 1 grants FU0,FU1 → next cycle lanes (rob 4, rob 5), ptr=2.
  - Cycle 2 grants FU2,FU3 → lanes (6, 7), ptr=0.
  - bcast_count=4 after both broadcasts.
- Wrap: ptr=3, only FU0 and FU3 valid → lane0 from FU3 (cdb_fu_idx=3), lane1 from FU0, ptr=1.
- Single requester FU2 (rd_v=0xDEADBEEF, pd=9), ptr=0:
  - Next cycle lane0 valid, pd=9, value 0xDEADBEEF.
  - cdb_valid[1]=0, ptr=3.
- Backpressure: FU0..FU2 valid continuously, ptr=0:
  - FU2 sees fu_ready=0 in cycle 1 and holds its payload.
  - FU2 is granted in cycle 2; its payload is broadcast unchanged exactly once.
- Flush with FU1 valid:
  - fu_ready[1]=0; next cycle cdb_valid=00.
  - ptr and bcast_count unchanged.
  - FU1 is granted the cycle after flush deasserts.
- Assert rst mid-stream with lanes valid:
  - cdb_valid=0 immediately, without waiting for a clock edge.
  - ptr=0 and bcast_count=0.
  - After release, FU0 has first priority.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdb_arbiter : round-robin grant of SS common-data-bus lanes to FU results
// Revision    : 1.0
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int SS        = 2,
  parameter int FU_COUNT  = 4,
  parameter int ROB_DEPTH = 8,
  parameter int PREG_W    = 6,
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH),
  localparam int FU_IDX_W  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [FU_COUNT-1:0]                  fu_valid_i,
  input  logic [FU_COUNT-1:0][ROB_IDX_W-1:0]   fu_rob_id_i,
  input  logic [FU_COUNT-1:0][PREG_W-1:0]      fu_pd_i,
  input  logic [FU_COUNT-1:0][31:0]            fu_rd_v_i,
  output logic [FU_COUNT-1:0]                  fu_ready_o,
  output logic [SS-1:0]                        cdb_valid_o,
  output logic [SS-1:0][ROB_IDX_W-1:0]         cdb_rob_id_o,
  output logic [SS-1:0][PREG_W-1:0]            cdb_pd_o,
  output logic [SS-1:0][31:0]                  cdb_rd_v_o,
  output logic [SS-1:0][FU_IDX_W-1:0]          cdb_fu_idx_o,
  output logic [31:0]                          bcast_count_o
);

  logic [FU_IDX_W-1:0]                 ptr_q, ptr_d;
  logic [SS-1:0]                       cdb_valid_q, cdb_valid_d;
  logic [SS-1:0][ROB_IDX_W-1:0]        cdb_rob_id_q;
  logic [SS-1:0][PREG_W-1:0]           cdb_pd_q;
  logic [SS-1:0][31:0]                 cdb_rd_v_q;
  logic [SS-1:0][FU_IDX_W-1:0]         cdb_fu_idx_q;
  logic [31:0]                         bcast_count_q, bcast_count_d;

  logic [FU_COUNT-1:0]                 grant;
  logic [SS-1:0][FU_IDX_W-1:0]         lane_src;
  logic [FU_IDX_W-1:0]                 scan_idx;
  logic [FU_IDX_W-1:0]                 last_idx;
  int                                  ngrant;

  // Scan from ptr with wrap; the k-th valid FU found takes lane k.
  always_comb begin
    grant       = '0;
    lane_src    = '0;
    cdb_valid_d = '0;
    scan_idx    = '0;
    last_idx    = '0;
    ngrant      = 0;
    for (int i = 0; i < FU_COUNT; i++) begin
      scan_idx = FU_IDX_W'((int'(ptr_q) + i) % FU_COUNT);
      if (!rst && !flush_i && fu_valid_i[scan_idx] && (ngrant < SS)) begin
        grant[scan_idx]     = 1'b1;
        cdb_valid_d[ngrant] = 1'b1;
        lane_src[ngrant]    = scan_idx;
        last_idx            = scan_idx;
        ngrant              = ngrant + 1;
      end
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    bcast_count_d = bcast_count_q + 32'(ngrant);
    if (ngrant != 0) begin
      ptr_d = FU_IDX_W'((int'(last_idx) + 1) % FU_COUNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      cdb_valid_q   <= '0;
      cdb_rob_id_q  <= '0;
      cdb_pd_q      <= '0;
      cdb_rd_v_q    <= '0;
      cdb_fu_idx_q  <= '0;
      bcast_count_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      bcast_count_q <= bcast_count_d;
      // Idle lanes keep their last payload.
      for (int k = 0; k < SS; k++) begin
        if (cdb_valid_d[k]) begin
          cdb_rob_id_q[k] <= fu_rob_id_i[lane_src[k]];
          cdb_pd_q[k]     <= fu_pd_i[lane_src[k]];
          cdb_rd_v_q[k]   <= fu_rd_v_i[lane_src[k]];
          cdb_fu_idx_q[k] <= lane_src[k];
        end
      end
    end
  end

  assign fu_ready_o    = grant;
  assign cdb_valid_o   = cdb_valid_q;
  assign cdb_rob_id_o  = cdb_rob_id_q;
  assign cdb_pd_o      = cdb_pd_q;
  assign cdb_rd_v_o    = cdb_rd_v_q;
  assign cdb_fu_idx_o  = cdb_fu_idx_q;
  assign bcast_count_o = bcast_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cdb_arbiter : scoreboard bench for cdb_arbiter (SS=2, FU_COUNT=4)
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic [3:0]        fu_valid_i;
  logic [3:0][2:0]   fu_rob_id_i;
  logic [3:0][5:0]   fu_pd_i;
  logic [3:0][31:0]  fu_rd_v_i;
  logic [3:0]        fu_ready_o;
  logic [1:0]        cdb_valid_o;
  logic [1:0][2:0]   cdb_rob_id_o;
  logic [1:0][5:0]   cdb_pd_o;
  logic [1:0][31:0]  cdb_rd_v_o;
  logic [1:0][1:0]   cdb_fu_idx_o;
  logic [31:0]       bcast_count_o;

  cdb_arbiter #(.SS(2), .FU_COUNT(4), .ROB_DEPTH(8), .PREG_W(6)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .fu_valid_i(fu_valid_i), .fu_rob_id_i(fu_rob_id_i), .fu_pd_i(fu_pd_i),
    .fu_rd_v_i(fu_rd_v_i), .fu_ready_o(fu_ready_o), .cdb_valid_o(cdb_valid_o),
    .cdb_rob_id_o(cdb_rob_id_o), .cdb_pd_o(cdb_pd_o), .cdb_rd_v_o(cdb_rd_v_o),
    .cdb_fu_idx_o(cdb_fu_idx_o), .bcast_count_o(bcast_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [2:0]  rob;
    logic [5:0]  pd;
    logic [31:0] v;
    logic [1:0]  fu;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every broadcast seen must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (cdb_valid_o[k]) begin
          if (q.size() == 0) begin
            chk("unexpected_bcast_lane", 32'(k), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("lane_no",   32'(k),              32'(e.lane));
            chk("lane_rob",  32'(cdb_rob_id_o[k]), 32'(e.rob));
            chk("lane_pd",   32'(cdb_pd_o[k]),     32'(e.pd));
            chk("lane_val",  cdb_rd_v_o[k],        e.v);
            chk("lane_fu",   32'(cdb_fu_idx_o[k]), 32'(e.fu));
          end
        end
      end
    end
  end

  task automatic setp(input int i, input logic [2:0] r, input logic [5:0] p, input logic [31:0] v);
    fu_rob_id_i[i] = r;
    fu_pd_i[i]     = p;
    fu_rd_v_i[i]   = v;
  endtask

  task automatic push_fu(input int lane, input int fu);
    exp_t e;
    e.lane = lane;
    e.rob  = fu_rob_id_i[fu];
    e.pd   = fu_pd_i[fu];
    e.v    = fu_rd_v_i[fu];
    e.fu   = 2'(fu);
    q.push_back(e);
  endtask

  // One cycle: drive, check grants, queue expected lanes (l0/l1 = source FU or -1).
  task automatic cyc(input logic [3:0] v, input logic fl, input logic [3:0] er,
                     input int l0, input int l1, input bit push);
    fu_valid_i = v;
    flush_i    = fl;
    #3;
    chk("fu_ready", 32'(fu_ready_o), 32'(er));
    if (push && l0 >= 0) push_fu(0, l0);
    if (push && l1 >= 0) push_fu(1, l1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    flush_i    = 1'b0;
    fu_valid_i = 4'b1111;
    for (int i = 0; i < 4; i++) setp(i, 3'(4 + i), 6'(10 + i), 32'h1000 + 32'(i));
    #2;
    chk("rst_ready",     32'(fu_ready_o),  32'h0);
    chk("rst_cdb_valid", 32'(cdb_valid_o), 32'h0);
    chk("rst_bcast",     bcast_count_o,    32'h0);
    chk("rst_rob0",      32'(cdb_rob_id_o[0]), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four valid: two rounds of two grants.
    cyc(4'b1111, 1'b0, 4'b0011, 0, 1, 1'b1);
    cyc(4'b1100, 1'b0, 4'b1100, 2, 3, 1'b1);
    chk("bcast_after_4", bcast_count_o, 32'd4);

    // Move ptr to 3, then wrap with FU3 and FU0.
    cyc(4'b0110, 1'b0, 4'b0110, 1, 2, 1'b1);
    cyc(4'b1001, 1'b0, 4'b1001, 3, 0, 1'b1);
    chk("wrap_lane0_fu", 32'(cdb_fu_idx_o[0]), 32'd3);

    // ptr 1 -> 0, then a lone FU2 request.
    cyc(4'b1100, 1'b0, 4'b1100, 2, 3, 1'b1);
    setp(2, 3'd1, 6'd9, 32'hDEAD_BEEF);
    cyc(4'b0100, 1'b0, 4'b0100, 2, -1, 1'b1);
    chk("single_cdb_valid", 32'(cdb_valid_o), 32'b01);
    chk("single_pd",        32'(cdb_pd_o[0]), 32'd9);
    chk("bcast_after_11",   bcast_count_o,    32'd11);

    // ptr 3 -> 0, then backpressure on FU2.
    cyc(4'b1000, 1'b0, 4'b1000, 3, -1, 1'b1);
    setp(2, 3'd2, 6'd22, 32'hC0DE_0002);
    cyc(4'b0111, 1'b0, 4'b0011, 0, 1, 1'b1);
    setp(0, 3'd0, 6'd30, 32'hA000_0000);
    setp(1, 3'd3, 6'd31, 32'hA000_0001);
    cyc(4'b0111, 1'b0, 4'b0101, 2, 0, 1'b1);
    cyc(4'b0010, 1'b0, 4'b0010, 1, -1, 1'b1);
    chk("bcast_after_17", bcast_count_o, 32'd17);

    // Flush with FU1 waiting; the previous broadcast is still visible this cycle.
    setp(1, 3'd6, 6'd40, 32'h5555_AAAA);
    cyc(4'b0010, 1'b1, 4'b0000, -1, -1, 1'b0);
    chk("flush_cdb_valid", 32'(cdb_valid_o), 32'h0);
    chk("flush_bcast",     bcast_count_o,    32'd17);
    cyc(4'b0010, 1'b0, 4'b0010, 1, -1, 1'b1);
    chk("post_flush_bcast", bcast_count_o, 32'd18);

    // Async reset while lanes are valid; those broadcasts must vanish.
    cyc(4'b1111, 1'b0, 4'b1100, -1, -1, 1'b0);
    chk("pre_rst_cdb_valid", 32'(cdb_valid_o), 32'b11);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_cdb_valid", 32'(cdb_valid_o), 32'h0);
    chk("async_rst_bcast",     bcast_count_o,    32'h0);
    chk("async_rst_ready",     32'(fu_ready_o),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    setp(0, 3'd7, 6'd50, 32'h0BAD_F00D);
    setp(1, 3'd5, 6'd51, 32'h1234_5678);
    cyc(4'b1111, 1'b0, 4'b0011, 0, 1, 1'b1);
    cyc(4'b0000, 1'b0, 4'b0000, -1, -1, 1'b0);
    chk("bcast_after_rst", bcast_count_o, 32'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
